// File: rtl/row_crop_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | row_crop_pkg : shared types and helpers for the row crop stage    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package row_crop_pkg;

  typedef enum logic [1:0] {
    S_SKIP = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int SOF_BIT = 0;

  function automatic int cnt_width(input int pad);
    return $clog2(pad + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_crop_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | row_crop_if : AXI-Stream pixel bus with master/slave modports     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface row_crop_if #(
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int TDATA_WIDTH = 8
);
  logic [TUSER_WIDTH-1:0] tuser;
  logic [TDEST_WIDTH-1:0] tdest;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tuser, tdest, tvalid, tlast, tdata, input tready);
  modport slave  (input tuser, tdest, tvalid, tlast, tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/row_crop_axis_reg_slice.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_reg_slice : registered AXI-Stream output stage               |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module axis_reg_slice #(
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int TDATA_WIDTH = 8
) (
  input  wire logic                   clk,
  input  wire logic                   aresetn,
  input  wire logic                   in_valid,
  output logic                        in_ready,
  input  wire logic [TDATA_WIDTH-1:0] in_data,
  input  wire logic [TUSER_WIDTH-1:0] in_user,
  input  wire logic [TDEST_WIDTH-1:0] in_dest,
  input  wire logic                   in_last,
  row_crop_if.master                  m_axis
);
  logic                   valid_q;
  logic                   last_q;
  logic [TDATA_WIDTH-1:0] data_q;
  logic [TUSER_WIDTH-1:0] user_q;
  logic [TDEST_WIDTH-1:0] dest_q;

  // Ready depends only on registered valid and downstream ready.
  assign in_ready = ~valid_q | m_axis.tready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      dest_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        last_q <= in_last;
        data_q <= in_data;
        user_q <= in_user;
        dest_q <= in_dest;
      end
    end
  end

  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tuser  = user_q;
  assign m_axis.tdest  = dest_q;
endmodule
`default_nettype wire

// File: rtl/row_crop.sv
`default_nettype none
// +------------------------------------------------------------------+
// | row_crop : strips PAD beats from both ends of each row, moves SOF |
// | optional macro ROW_CROP_STATS_EN adds row_cnt/short_cnt. rev 1.0  |
// +------------------------------------------------------------------+
module row_crop
  import row_crop_pkg::*;
#(
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int TDATA_WIDTH = 8,
  parameter int PAD         = 2
) (
  input  wire logic  clk,
  input  wire logic  aresetn,
  row_crop_if.slave  s_axis,
  row_crop_if.master m_axis,
  output logic       err_short_row
`ifdef ROW_CROP_STATS_EN
  ,
  output logic [15:0] row_cnt,
  output logic [7:0]  short_cnt
`endif
);
  localparam int CW = cnt_width(PAD);
  localparam logic [CW-1:0] PAD_LAST = CW'(PAD - 1);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   s_ready, accept, push, emit, short_row, sof_pending;
  logic [TUSER_WIDTH-1:0] emit_user;

  logic [TDATA_WIDTH-1:0] sh_data [PAD];
  logic [TUSER_WIDTH-1:0] sh_user [PAD];
  logic [TDEST_WIDTH-1:0] sh_dest [PAD];

  assign s_axis.tready = s_ready;
  assign accept        = s_axis.tvalid & s_ready;
  assign push          = accept & (state != S_SKIP);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_SKIP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    emit      = 1'b0;
    short_row = 1'b0;
    if (accept) begin
      case (state)
        S_SKIP, S_FILL: begin
          if (s_axis.tlast) begin
            short_row = 1'b1;
            state_nxt = S_SKIP;
            cnt_nxt   = '0;
          end else if (cnt == PAD_LAST) begin
            state_nxt = (state == S_SKIP) ? S_FILL : S_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_RUN: begin
          emit = 1'b1;
          if (s_axis.tlast) state_nxt = S_SKIP;
        end
        default: begin
          state_nxt = S_SKIP;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Oldest entry sits at index PAD-1 once the buffer is full.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < PAD; i++) begin
        sh_data[i] <= '0;
        sh_user[i] <= '0;
        sh_dest[i] <= '0;
      end
    end else if (push) begin
      sh_data[0] <= s_axis.tdata;
      sh_user[0] <= s_axis.tuser;
      sh_dest[0] <= s_axis.tdest;
      for (int i = 1; i < PAD; i++) begin
        sh_data[i] <= sh_data[i-1];
        sh_user[i] <= sh_user[i-1];
        sh_dest[i] <= sh_dest[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sof_pending   <= 1'b0;
      err_short_row <= 1'b0;
    end else begin
      sof_pending   <= (sof_pending & ~emit) | (accept & s_axis.tuser[SOF_BIT]);
      err_short_row <= short_row;
    end
  end

  always_comb begin
    emit_user          = sh_user[PAD-1];
    emit_user[SOF_BIT] = sof_pending;
  end

  axis_reg_slice #(
    .TUSER_WIDTH(TUSER_WIDTH),
    .TDEST_WIDTH(TDEST_WIDTH),
    .TDATA_WIDTH(TDATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .aresetn  (aresetn),
    .in_valid (emit),
    .in_ready (s_ready),
    .in_data  (sh_data[PAD-1]),
    .in_user  (emit_user),
    .in_dest  (sh_dest[PAD-1]),
    .in_last  (s_axis.tlast),
    .m_axis   (m_axis)
  );

`ifdef ROW_CROP_STATS_EN
  logic [15:0] row_base;

  // An emitted SOF restarts the count so the frame's first row ends as 1.
  always_comb row_base = (emit && sof_pending) ? 16'd0 : row_cnt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      row_cnt   <= '0;
      short_cnt <= '0;
    end else begin
      if (emit && s_axis.tlast && row_base != 16'hFFFF) row_cnt <= row_base + 16'd1;
      else                                               row_cnt <= row_base;
      if (short_row && short_cnt != 8'hFF) short_cnt <= short_cnt + 8'd1;
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_row_crop.sv
`default_nettype none
// Scoreboard bench for row_crop: directed rows, expected beats queued, monitor compares.
module tb_row_crop;
  localparam int TUW = 5;
  localparam int TDW = 2;
  localparam int DW  = 8;
  localparam int PAD = 2;

  typedef struct packed {
    logic           last;
    logic [TDW-1:0] dest;
    logic [TUW-1:0] user;
    logic [DW-1:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic err;
`ifdef ROW_CROP_STATS_EN
  logic [15:0] row_cnt;
  logic [7:0]  short_cnt;
`endif

  beat_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int err_seen = 0;
  int rdy_mode = 0;

  always #5 clk = ~clk;

  row_crop_if #(.TUSER_WIDTH(TUW), .TDEST_WIDTH(TDW), .TDATA_WIDTH(DW)) s_if ();
  row_crop_if #(.TUSER_WIDTH(TUW), .TDEST_WIDTH(TDW), .TDATA_WIDTH(DW)) m_if ();

  row_crop #(.TUSER_WIDTH(TUW), .TDEST_WIDTH(TDW), .TDATA_WIDTH(DW), .PAD(PAD)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis        (s_if.slave),
    .m_axis        (m_if.master),
    .err_short_row (err)
`ifdef ROW_CROP_STATS_EN
    ,
    .row_cnt       (row_cnt),
    .short_cnt     (short_cnt)
`endif
  );

  function automatic beat_t mk(input int d, input bit sof, input bit last);
    beat_t b;
    b.data = DW'(d);
    b.user = {b.data[3:0], sof};
    b.dest = b.data[1:0];
    b.last = last;
    return b;
  endfunction

  task automatic exp_push(input int d, input bit sof, input bit last);
    exp_q.push_back(mk(d, sof, last));
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input int d, input bit sof, input bit last);
    beat_t b;
    int    i;
    bit    done;
    b = mk(d, sof, last);
    s_if.tvalid = 1'b1;
    s_if.tdata  = b.data;
    s_if.tuser  = b.user;
    s_if.tdest  = b.dest;
    s_if.tlast  = last;
    i = 0;
    done = 1'b0;
    while (!done && i < 100) begin
      @(negedge clk);
      done = s_if.tready;
      @(posedge clk);
      #1;
      i++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: beat %0d not accepted, expected accept within 100 cycles", d);
    end
  endtask

  task automatic send_row(input int base, input int len, input bit sof);
    for (int k = 0; k < len; k++) send_beat(base + k, sof && (k == 0), k == len - 1);
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input string nm, input int exp_err);
    int i;
    idle();
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check({nm, "_err_pulses"}, 32'(err_seen), 32'(exp_err));
    err_seen = 0;
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ~m_if.tready;
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin : mon
    beat_t act;
    beat_t e;
    if (aresetn) begin
      if (err) err_seen++;
      if (m_if.tvalid && !m_if.tready) begin
        n_vec++;
        if (s_if.tready !== 1'b0) begin
          n_err++;
          $display("FAIL ready_rule: s_tready=%b while output stalled, expected 0", s_if.tready);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        act = {m_if.tlast, m_if.tdest, m_if.tuser, m_if.tdata};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no output", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL out_beat: got 0x%0h, expected 0x%0h", act, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    time t1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tdest  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tuser, m_if.tdest, err}), 32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd1);
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Row of 10 with SOF on beat 0
    for (int d = 2; d <= 7; d++) exp_push(d, d == 2, d == 7);
    send_row(0, 10, 1'b1);
    drain("s1", 0);
`ifdef ROW_CROP_STATS_EN
    check("s1_row_cnt", 32'(row_cnt), 32'd1);
`endif

    // Same row under alternating output ready
    rdy_mode = 1;
    for (int d = 2; d <= 7; d++) exp_push(d, d == 2, d == 7);
    send_row(0, 10, 1'b1);
    drain("s2", 0);
    rdy_mode = 0;
    @(posedge clk);
    #1;
`ifdef ROW_CROP_STATS_EN
    check("s2_row_cnt", 32'(row_cnt), 32'd1);
`endif

    // Short row then a 5-beat row; SOF carries over to beat 12
    exp_push(12, 1'b1, 1'b1);
    send_row(0, 4, 1'b1);
    send_row(10, 5, 1'b0);
    drain("s3", 1);
`ifdef ROW_CROP_STATS_EN
    check("s3_short_cnt", 32'(short_cnt), 32'd1);
    check("s3_row_cnt", 32'(row_cnt), 32'd1);
`endif

    // Three back-to-back 8-beat rows
    for (int d = 2; d <= 5; d++)   exp_push(d, d == 2, d == 5);
    for (int d = 10; d <= 13; d++) exp_push(d, 1'b0, d == 13);
    for (int d = 18; d <= 21; d++) exp_push(d, 1'b0, d == 21);
    t0 = $time;
    send_row(0, 8, 1'b1);
    send_row(8, 8, 1'b0);
    send_row(16, 8, 1'b0);
    t1 = $time;
    check("s4_input_cycles", 32'((t1 - t0) / 10), 32'd24);
    drain("s4", 0);
`ifdef ROW_CROP_STATS_EN
    check("s4_row_cnt", 32'(row_cnt), 32'd3);
`endif

    // Reset mid-row with beat 2 parked in the output register
    rdy_mode = 2;
    @(posedge clk);
    #1;
    for (int k = 0; k <= 4; k++) send_beat(k, k == 0, 1'b0);
    idle();
    check("s5_parked_valid", 32'(m_if.tvalid), 32'd1);
    check("s5_parked_data", 32'(m_if.tdata), 32'd2);
    aresetn = 1'b0;
    #1;
    check("s5_rst_outputs", 32'({m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tuser, m_if.tdest, err}), 32'd0);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    m_if.tready = 1'b1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    exp_push(32, 1'b1, 1'b0);
    exp_push(33, 1'b0, 1'b1);
    send_row(30, 6, 1'b1);
    drain("s5", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
